systolic_feeder: RTL and testbench

- Parametrised successor to the fixed 4x4 input/weight buffer front-end of the systolic array.
- Replaces the externally driven per-buffer ctlbw/ctlbin enables with an internal sequencer. The sequencer accepts weight and input streams over valid/ready, stores them in ROWS weight lanes and COLS input lanes of VECTOR entries each, then replays them into the array as a skewed (diagonal wavefront) feed.
- Sits between the host stream interface and the array's ws_array/ins_array ports.

---
 rtl/systolic_feeder_pkg.sv | 23 ++
 rtl/systolic_feeder_if.sv | 32 +++
 rtl/systolic_feeder_lane.sv | 58 +++++
 rtl/systolic_feeder.sv | 181 ++++++++++++++++++
 tb/tb_systolic_feeder.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/systolic_feeder_pkg.sv
// Shared types and sizing helpers for the systolic array feeder.
package systolic_feeder_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoadW,
    StLoadIn,
    StFeed,
    StDone
  } state_e;

  // Number of cycles the skewed wavefront needs to drain all lanes.
  function automatic int unsigned feed_len(int unsigned vector, int unsigned rows,
                                           int unsigned cols);
    return vector + ((rows > cols) ? rows : cols) - 1;
  endfunction

  // Bits needed for a counter that reaches max_val; never less than one.
  function automatic int unsigned cnt_width(int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/systolic_feeder_if.sv
// Host stream and array feed bundle for systolic_feeder.
interface systolic_feeder_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned ROWS  = 4,
  parameter int unsigned COLS  = 4
) ();

  logic                  start;
  logic [WIDTH-1:0]      w_data;
  logic                  w_valid;
  logic                  w_ready;
  logic [WIDTH-1:0]      in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [ROWS*WIDTH-1:0] ws_array;
  logic [COLS*WIDTH-1:0] ins_array;
  logic [ROWS-1:0]       ws_vld;
  logic [COLS-1:0]       ins_vld;
  logic                  busy;
  logic                  done;

  modport master (
    output start, w_data, w_valid, in_data, in_valid,
    input  w_ready, in_ready, ws_array, ins_array, ws_vld, ins_vld, busy, done
  );

  modport slave (
    input  start, w_data, w_valid, in_data, in_valid,
    output w_ready, in_ready, ws_array, ins_array, ws_vld, ins_vld, busy, done
  );

endinterface

// File: rtl/systolic_feeder_lane.sv
// One feed lane: VECTOR-entry register file replayed with a fixed skew.
module systolic_feeder_lane
  import systolic_feeder_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned VECTOR = 4,
  parameter int unsigned SKEW   = 0,
  parameter int unsigned TW     = 3,
  parameter int unsigned SW     = cnt_width(VECTOR - 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [SW-1:0]    wr_slot,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             feed_en,
  input  logic [TW-1:0]    feed_t,
  output logic [WIDTH-1:0] data,
  output logic             vld
);

  logic [WIDTH-1:0] mem_q [VECTOR];
  logic [WIDTH-1:0] data_q, data_d;
  logic             vld_q, vld_d;
  logic [SW-1:0]    rd_slot;
  int unsigned      offs;

  always_comb begin
    offs    = 32'(feed_t) - SKEW;
    rd_slot = SW'(offs);
    vld_d   = feed_en && (32'(feed_t) >= SKEW) && (offs < VECTOR);
    data_d  = '0;
    if (vld_d) begin
      // Forward a slot written on the same edge it is first replayed.
      data_d = (wr_en && (wr_slot == rd_slot)) ? wr_data : mem_q[rd_slot];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(VECTOR); i++) begin
        mem_q[i] <= '0;
      end
      data_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      if (wr_en) begin
        mem_q[wr_slot] <= wr_data;
      end
      data_q <= data_d;
      vld_q  <= vld_d;
    end
  end

  assign data = data_q;
  assign vld  = vld_q;

endmodule

// File: rtl/systolic_feeder.sv
// Loads weight and input streams into per-lane buffers, then replays them as a
// skewed diagonal wavefront into the systolic array.
module systolic_feeder
  import systolic_feeder_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned ROWS   = 4,
  parameter int unsigned COLS   = 4,
  parameter int unsigned VECTOR = 4
) (
  input logic         clk,
  input logic         rst,
  systolic_feeder_if.slave bus
);

  localparam int unsigned T        = feed_len(VECTOR, ROWS, COLS);
  localparam int unsigned MaxLanes = (ROWS > COLS) ? ROWS : COLS;
  localparam int unsigned LW       = cnt_width(MaxLanes - 1);
  localparam int unsigned SW       = cnt_width(VECTOR - 1);
  localparam int unsigned TW       = cnt_width(T - 1);

  localparam logic [LW-1:0] LastRow  = LW'(ROWS - 1);
  localparam logic [LW-1:0] LastCol  = LW'(COLS - 1);
  localparam logic [SW-1:0] LastSlot = SW'(VECTOR - 1);
  localparam logic [TW-1:0] LastT    = TW'(T - 1);

  state_e        state_q, state_d;
  logic [LW-1:0] lane_q, lane_d;
  logic [SW-1:0] slot_q, slot_d;
  logic [TW-1:0] t_q, t_d;
  logic          w_ready_q, w_ready_d;
  logic          in_ready_q, in_ready_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          w_fire, in_fire, beat, last_beat;
  logic [LW-1:0] last_lane;
  logic          feed_en;

  assign w_fire    = bus.w_valid && w_ready_q;
  assign in_fire   = bus.in_valid && in_ready_q;
  assign beat      = w_fire || in_fire;
  assign last_lane = (state_q == StLoadW) ? LastRow : LastCol;
  assign last_beat = beat && (slot_q == LastSlot) && (lane_q == last_lane);

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    slot_d  = slot_q;
    t_d     = t_q;

    // Lane-major beat position shared by both load phases.
    if (beat) begin
      if (slot_q == LastSlot) begin
        slot_d = '0;
        lane_d = last_beat ? '0 : lane_q + 1'b1;
      end else begin
        slot_d = slot_q + 1'b1;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StLoadW;
          lane_d  = '0;
          slot_d  = '0;
        end
      end
      StLoadW: begin
        if (last_beat) state_d = StLoadIn;
      end
      StLoadIn: begin
        if (last_beat) begin
          state_d = StFeed;
          t_d     = '0;
        end
      end
      StFeed: begin
        if (t_q == LastT) begin
          state_d = StDone;
          t_d     = '0;
        end else begin
          t_d = t_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    w_ready_d  = (state_d == StLoadW);
    in_ready_d = (state_d == StLoadIn);
    busy_d     = (state_d != StIdle);
    done_d     = (state_d == StDone);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      lane_q     <= '0;
      slot_q     <= '0;
      t_q        <= '0;
      w_ready_q  <= 1'b0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      lane_q     <= lane_d;
      slot_q     <= slot_d;
      t_q        <= t_d;
      w_ready_q  <= w_ready_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Lane registers load the value for the count entering t_q, so the feed
  // lines up with the FEED state and is already cleared in DONE.
  assign feed_en = (state_d == StFeed);

  logic [ROWS*WIDTH-1:0] ws_array;
  logic [COLS*WIDTH-1:0] ins_array;
  logic [ROWS-1:0]       ws_vld;
  logic [COLS-1:0]       ins_vld;

  for (genvar r = 0; r < int'(ROWS); r++) begin : g_w_lane
    logic we;
    assign we = w_fire && (lane_q == LW'(r));
    systolic_feeder_lane #(
      .WIDTH (WIDTH),
      .VECTOR(VECTOR),
      .SKEW  (r),
      .TW    (TW),
      .SW    (SW)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .wr_en  (we),
      .wr_slot(slot_q),
      .wr_data(bus.w_data),
      .feed_en(feed_en),
      .feed_t (t_d),
      .data   (ws_array[r*WIDTH +: WIDTH]),
      .vld    (ws_vld[r])
    );
  end

  for (genvar c = 0; c < int'(COLS); c++) begin : g_in_lane
    logic we;
    assign we = in_fire && (lane_q == LW'(c));
    systolic_feeder_lane #(
      .WIDTH (WIDTH),
      .VECTOR(VECTOR),
      .SKEW  (c),
      .TW    (TW),
      .SW    (SW)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .wr_en  (we),
      .wr_slot(slot_q),
      .wr_data(bus.in_data),
      .feed_en(feed_en),
      .feed_t (t_d),
      .data   (ins_array[c*WIDTH +: WIDTH]),
      .vld    (ins_vld[c])
    );
  end

  assign bus.w_ready   = w_ready_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.ws_array  = ws_array;
  assign bus.ins_array = ins_array;
  assign bus.ws_vld    = ws_vld;
  assign bus.ins_vld   = ins_vld;

endmodule

// File: tb/tb_systolic_feeder.sv
// Scoreboard bench: default 4x4x4 feeder plus a 2x3 VECTOR=1 instance.
module tb_systolic_feeder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  systolic_feeder_if #(.WIDTH(8), .ROWS(4), .COLS(4)) bus_a ();
  systolic_feeder_if #(.WIDTH(8), .ROWS(2), .COLS(3)) bus_b ();

  systolic_feeder #(.WIDTH(8), .ROWS(4), .COLS(4), .VECTOR(4)) u_dut_a (
    .clk(clk),
    .rst(rst),
    .bus(bus_a)
  );

  systolic_feeder #(.WIDTH(8), .ROWS(2), .COLS(3), .VECTOR(1)) u_dut_b (
    .clk(clk),
    .rst(rst),
    .bus(bus_b)
  );

  typedef struct packed {
    logic [63:0] ws;
    logic [63:0] ins;
    logic [7:0]  wv;
    logic [7:0]  iv;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  int   n_vec  = 0;
  int   n_err  = 0;
  int   done_a = 0;
  int   done_b = 0;

  task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected skewed wavefront, built straight from the loaded words.
  task automatic push_exp(int sel, int rows, int cols, int vec, input int w[16],
                          input int x[16]);
    int   tt;
    int   d;
    exp_t e;
    tt = vec + ((rows > cols) ? rows : cols) - 1;
    for (int t = 0; t < tt; t++) begin
      e = '0;
      for (int r = 0; r < rows; r++) begin
        d = t - r;
        if (d >= 0 && d < vec) begin
          e.ws[r*8 +: 8] = 8'(w[r*vec + d]);
          e.wv[r]        = 1'b1;
        end
      end
      for (int c = 0; c < cols; c++) begin
        d = t - c;
        if (d >= 0 && d < vec) begin
          e.ins[c*8 +: 8] = 8'(x[c*vec + d]);
          e.iv[c]         = 1'b1;
        end
      end
      if (sel == 0) qa.push_back(e);
      else qb.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if ((bus_a.ws_vld != 0) || (bus_a.ins_vld != 0)) begin
        if (qa.size() == 0) begin
          check_eq("a_unexpected_feed", 64'(qa.size()), 64'(1));
        end else begin
          ea = qa.pop_front();
          check_eq("a_ws_array", 64'(bus_a.ws_array), ea.ws);
          check_eq("a_ws_vld", 64'(bus_a.ws_vld), 64'(ea.wv));
          check_eq("a_ins_array", 64'(bus_a.ins_array), ea.ins);
          check_eq("a_ins_vld", 64'(bus_a.ins_vld), 64'(ea.iv));
        end
      end
      if (bus_a.done) begin
        done_a++;
        check_eq("a_done_all_fed", 64'(qa.size()), 64'(0));
        check_eq("a_done_outputs", 64'({bus_a.ws_array, bus_a.ins_array}), 64'(0));
      end
      if ((bus_b.ws_vld != 0) || (bus_b.ins_vld != 0)) begin
        if (qb.size() == 0) begin
          check_eq("b_unexpected_feed", 64'(qb.size()), 64'(1));
        end else begin
          eb = qb.pop_front();
          check_eq("b_ws_array", 64'(bus_b.ws_array), eb.ws);
          check_eq("b_ws_vld", 64'(bus_b.ws_vld), 64'(eb.wv));
          check_eq("b_ins_array", 64'(bus_b.ins_array), eb.ins);
          check_eq("b_ins_vld", 64'(bus_b.ins_vld), 64'(eb.iv));
        end
      end
      if (bus_b.done) begin
        done_b++;
        check_eq("b_done_all_fed", 64'(qb.size()), 64'(0));
      end
    end
  end

  task automatic set_start(int sel, logic v);
    if (sel == 0) bus_a.start = v;
    else bus_b.start = v;
  endtask

  task automatic set_w(int sel, logic v, logic [7:0] d);
    if (sel == 0) begin
      bus_a.w_valid = v;
      bus_a.w_data  = d;
    end else begin
      bus_b.w_valid = v;
      bus_b.w_data  = d;
    end
  endtask

  task automatic set_in(int sel, logic v, logic [7:0] d);
    if (sel == 0) begin
      bus_a.in_valid = v;
      bus_a.in_data  = d;
    end else begin
      bus_b.in_valid = v;
      bus_b.in_data  = d;
    end
  endtask

  function automatic logic get_wready(int sel);
    return (sel == 0) ? bus_a.w_ready : bus_b.w_ready;
  endfunction

  function automatic logic get_inready(int sel);
    return (sel == 0) ? bus_a.in_ready : bus_b.in_ready;
  endfunction

  function automatic logic get_done(int sel);
    return (sel == 0) ? bus_a.done : bus_b.done;
  endfunction

  function automatic logic get_busy(int sel);
    return (sel == 0) ? bus_a.busy : bus_b.busy;
  endfunction

  // Start a job and stream nw weights then up to x_limit inputs; junk is
  // offered on the input stream during the weight phase.
  task automatic load_job(int sel, int nw, input int w[16], input int x[16], bit toggle,
                          int x_limit, output int w_rdy, output int x_rdy, output int stray);
    int   idx;
    int   cyc;
    logic v;
    w_rdy = 0;
    x_rdy = 0;
    stray = 0;
    @(negedge clk);
    set_start(sel, 1'b1);
    @(negedge clk);
    set_start(sel, 1'b0);
    idx = 0;
    cyc = 0;
    while (idx < nw && cyc < 200) begin
      v = toggle ? cyc[0] : 1'b1;
      set_w(sel, v, 8'(w[idx]));
      set_in(sel, 1'b1, 8'hEE);
      if (get_wready(sel)) w_rdy++;
      if (get_inready(sel)) stray++;
      if (v && get_wready(sel)) idx++;
      cyc++;
      @(negedge clk);
    end
    check_eq("w_beats_accepted", 64'(idx), 64'(nw));
    set_w(sel, 1'b0, 8'h00);
    idx = 0;
    cyc = 0;
    while (idx < x_limit && cyc < 200) begin
      set_in(sel, 1'b1, 8'(x[idx]));
      if (get_inready(sel)) x_rdy++;
      if (get_inready(sel)) idx++;
      cyc++;
      @(negedge clk);
    end
    check_eq("in_beats_accepted", 64'(idx), 64'(x_limit));
    set_in(sel, 1'b0, 8'h00);
  endtask

  task automatic wait_done(int sel);
    int c;
    c = 0;
    while (!get_done(sel) && c < 100) begin
      @(negedge clk);
      c++;
    end
    check_eq("done_seen", 64'(get_done(sel)), 64'(1));
    @(negedge clk);
    check_eq("idle_after_done", 64'(get_busy(sel)), 64'(0));
  endtask

  int w_main[16], x_main[16], w_alt[16], w_b[16], x_b[16];
  int w_rdy, x_rdy, stray;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      w_main[i] = i + 1;
      x_main[i] = 'h21 + i;
      w_alt[i]  = 'hA0 + 15 - i;
      w_b[i]    = 'h50 + i;
      x_b[i]    = 'h70 + i;
    end
    set_start(0, 1'b0); set_w(0, 1'b0, 8'h00); set_in(0, 1'b0, 8'h00);
    set_start(1, 1'b0); set_w(1, 1'b0, 8'h00); set_in(1, 1'b0, 8'h00);

    // Reset state.
    repeat (3) @(negedge clk);
    check_eq("rst_busy", 64'({bus_a.busy, bus_b.busy}), 64'(0));
    check_eq("rst_done", 64'({bus_a.done, bus_b.done}), 64'(0));
    check_eq("rst_ready", 64'({bus_a.w_ready, bus_a.in_ready, bus_b.w_ready}), 64'(0));
    check_eq("rst_feed_a", 64'({bus_a.ws_array, bus_a.ins_array}), 64'(0));
    check_eq("rst_vld", 64'({bus_a.ws_vld, bus_a.ins_vld, bus_b.ws_vld, bus_b.ins_vld}),
             64'(0));
    rst = 1'b1;

    // Abort mid input load with an asynchronous reset.
    load_job(0, 16, w_main, x_main, 1'b0, 5, w_rdy, x_rdy, stray);
    check_eq("abort_busy_before", 64'(bus_a.busy), 64'(1));
    #2 rst = 1'b0;
    #1;
    check_eq("abort_busy", 64'(bus_a.busy), 64'(0));
    check_eq("abort_ready", 64'({bus_a.w_ready, bus_a.in_ready}), 64'(0));
    check_eq("abort_outputs", 64'({bus_a.done, bus_a.ws_vld, bus_a.ins_vld}), 64'(0));
    @(negedge clk);
    rst = 1'b1;

    // Full job, valid held high, junk offered on the input stream early.
    push_exp(0, 4, 4, 4, w_main, x_main);
    load_job(0, 16, w_main, x_main, 1'b0, 16, w_rdy, x_rdy, stray);
    check_eq("steady_w_ready_cycles", 64'(w_rdy), 64'(16));
    check_eq("steady_in_ready_cycles", 64'(x_rdy), 64'(16));
    check_eq("in_ready_during_load_w", 64'(stray), 64'(0));
    wait_done(0);
    check_eq("done_count_job1", 64'(done_a), 64'(1));

    // Toggled weight valid: slower load, identical feed.
    push_exp(0, 4, 4, 4, w_main, x_main);
    load_job(0, 16, w_main, x_main, 1'b1, 16, w_rdy, x_rdy, stray);
    check_eq("toggle_w_ready_cycles", 64'(w_rdy), 64'(32));
    wait_done(0);
    check_eq("done_count_job2", 64'(done_a), 64'(2));

    // start pulsed during FEED must be ignored.
    push_exp(0, 4, 4, 4, w_alt, x_main);
    load_job(0, 16, w_alt, x_main, 1'b0, 16, w_rdy, x_rdy, stray);
    for (int c = 0; c < 20 && bus_a.ws_vld == 0; c++) @(negedge clk);
    set_start(0, 1'b1);
    repeat (2) @(negedge clk);
    set_start(0, 1'b0);
    wait_done(0);
    repeat (4) @(negedge clk);
    check_eq("start_in_feed_no_job", 64'(bus_a.busy), 64'(0));
    check_eq("done_count_job3", 64'(done_a), 64'(3));

    // Degenerate VECTOR=1 instance.
    push_exp(1, 2, 3, 1, w_b, x_b);
    load_job(1, 2, w_b, x_b, 1'b0, 3, w_rdy, x_rdy, stray);
    check_eq("b_w_ready_cycles", 64'(w_rdy), 64'(2));
    check_eq("b_in_ready_cycles", 64'(x_rdy), 64'(3));
    wait_done(1);
    check_eq("b_done_count", 64'(done_b), 64'(1));

    repeat (3) @(negedge clk);
    check_eq("a_queue_drained", 64'(qa.size()), 64'(0));
    check_eq("b_queue_drained", 64'(qb.size()), 64'(0));
    check_eq("a_done_total", 64'(done_a), 64'(3));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
